// File: rtl/chord_tone_gen.sv
// NCH-channel square-wave tone generator with per-channel half-period divisors and a
// single-entry divisor write buffer. Define CHORD_MIX_OUT_EN to add the registered 'mix' output.
module chord_tone_gen #(
   parameter int unsigned NCH  = 8,
   parameter int unsigned DIVW = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NCH-1:0]           key,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [$clog2(NCH)-1:0]   cfg_ch,
   input  logic [DIVW-1:0]          cfg_div,
   output logic [NCH-1:0]           tone,
   output logic [NCH-1:0]           active
`ifdef CHORD_MIX_OUT_EN
   ,
   output logic [$clog2(NCH+1)-1:0] mix
`endif
);

   localparam int unsigned CHW = $clog2(NCH);

   logic [NCH-1:0][DIVW-1:0] div_q, div_d;
   logic [NCH-1:0][DIVW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0][DIVW-1:0] eff_div;
   logic [NCH-1:0]           tone_q, tone_d;
   logic [NCH-1:0]           act_q, act_d;
   logic [NCH-1:0]           key_q;
   logic [NCH-1:0]           rise;
   logic [NCH-1:0]           hit;

   logic                     pend_q, pend_d;
   logic [CHW-1:0]           pend_ch_q, pend_ch_d;
   logic [DIVW-1:0]          pend_div_q, pend_div_d;
   logic                     pend_done;

   assign rise      = key & ~key_q;
   assign cfg_ready = ~pend_q;
   assign tone      = tone_q;
   assign active    = act_q;

   // Divisor a channel would use this cycle if the pending write is applied now.
   always_comb begin
      hit     = '0;
      eff_div = div_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         hit[i] = pend_q && (pend_ch_q == CHW'(i));
         if (hit[i]) begin
            eff_div[i] = pend_div_q;
         end
      end
   end

   always_comb begin
      div_d     = div_q;
      cnt_d     = cnt_q;
      tone_d    = tone_q;
      act_d     = act_q;
      // A pending write that matches no channel is discarded.
      pend_done = pend_q && (hit == '0);
      for (int unsigned i = 0; i < NCH; i++) begin
         if (act_q[i]) begin
            if (cnt_q[i] == '0) begin
               if (hit[i]) begin
                  div_d[i]  = pend_div_q;
                  pend_done = 1'b1;
               end
               // Stop only at the end of a low half so no high pulse is shortened.
               if ((eff_div[i] == '0) || (!key[i] && !tone_q[i])) begin
                  act_d[i]  = 1'b0;
                  tone_d[i] = 1'b0;
                  cnt_d[i]  = '0;
               end else begin
                  tone_d[i] = ~tone_q[i];
                  cnt_d[i]  = eff_div[i] - DIVW'(1);
               end
            end else begin
               cnt_d[i] = cnt_q[i] - DIVW'(1);
            end
         end else begin
            if (hit[i]) begin
               div_d[i]  = pend_div_q;
               pend_done = 1'b1;
            end
            if (rise[i] && (eff_div[i] != '0)) begin
               act_d[i]  = 1'b1;
               tone_d[i] = 1'b0;
               cnt_d[i]  = eff_div[i] - DIVW'(1);
            end
         end
      end
   end

   always_comb begin
      pend_d     = pend_q;
      pend_ch_d  = pend_ch_q;
      pend_div_d = pend_div_q;
      if (cfg_valid && cfg_ready) begin
         pend_d     = 1'b1;
         pend_ch_d  = cfg_ch;
         pend_div_d = cfg_div;
      end else if (pend_done) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         cnt_q      <= '0;
         tone_q     <= '0;
         act_q      <= '0;
         key_q      <= '0;
         pend_q     <= 1'b0;
         pend_ch_q  <= '0;
         pend_div_q <= '0;
      end else begin
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         tone_q     <= tone_d;
         act_q      <= act_d;
         key_q      <= key;
         pend_q     <= pend_d;
         pend_ch_q  <= pend_ch_d;
         pend_div_q <= pend_div_d;
      end
   end

`ifdef CHORD_MIX_OUT_EN
   localparam int unsigned MW = $clog2(NCH+1);

   logic [MW-1:0] mix_q, mix_d;

   always_comb begin
      mix_d = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         mix_d = mix_d + MW'(tone_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix_q <= '0;
      end else begin
         mix_q <= mix_d;
      end
   end

   assign mix = mix_q;
`endif

endmodule

// File: tb/tb_chord_tone_gen.sv
// Self-checking bench for chord_tone_gen: event-time reference model compared every cycle,
// directed literal checks, and randomized key/config traffic.
module tb_chord_tone_gen;

   localparam int NCH   = 8;
   localparam int DIVW  = 16;
   localparam int NCH1  = 6;
   localparam int DIVW1 = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    key;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [2:0]        cfg_ch;
   logic [DIVW-1:0]   cfg_div;
   logic [NCH-1:0]    tone;
   logic [NCH-1:0]    active;

   logic [NCH1-1:0]   key1;
   logic              cfg_valid1;
   logic              cfg_ready1;
   logic [2:0]        cfg_ch1;
   logic [DIVW1-1:0]  cfg_div1;
   logic [NCH1-1:0]   tone1;
   logic [NCH1-1:0]   active1;
`ifdef CHORD_MIX_OUT_EN
   logic [3:0]        mix;
   logic [2:0]        mix1;
`endif

   always #5 clk = ~clk;

   chord_tone_gen #(.NCH(NCH), .DIVW(DIVW)) u_dut (
      .clk(clk), .rst_n(rst_n), .key(key), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .tone(tone), .active(active)
`ifdef CHORD_MIX_OUT_EN
      , .mix(mix)
`endif
   );

   // Six channels on a 3-bit channel field, so channels 6 and 7 are out of range.
   chord_tone_gen #(.NCH(NCH1), .DIVW(DIVW1)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .key(key1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
      .cfg_ch(cfg_ch1), .cfg_div(cfg_div1), .tone(tone1), .active(active1)
`ifdef CHORD_MIX_OUT_EN
      , .mix(mix1)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, expv);
      end
   endtask

   // Reference model: each active channel remembers the absolute cycle of its next boundary.
   typedef struct {int ch; int dv;} wr_t;
   wr_t    pq[$];
   int     m_div  [NCH];
   longint m_end  [NCH];
   bit     m_tone [NCH];
   bit     m_act  [NCH];
   bit     m_keyp [NCH];
   int     m_mix;
   longint cyc;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_div[c] = 0; m_end[c] = 0; m_tone[c] = 0; m_act[c] = 0; m_keyp[c] = 0;
      end
      pq.delete();
      m_mix = 0;
      cyc   = 0;
   endtask

   task automatic model_step();
      int popc;
      bit empty;
      bit used;
      bit hit;
      int nd;
      popc  = 0;
      used  = 0;
      empty = (pq.size() == 0);
      for (int c = 0; c < NCH; c++) popc += int'(m_tone[c]);
      for (int c = 0; c < NCH; c++) begin
         hit = 0;
         nd  = m_div[c];
         if (!empty) begin
            if (pq[0].ch == c) begin
               hit = 1;
               nd  = pq[0].dv;
            end
         end
         if (m_act[c]) begin
            if (cyc == m_end[c]) begin
               if (hit) begin m_div[c] = nd; used = 1; end
               if (nd == 0 || (!key[c] && !m_tone[c])) begin
                  m_act[c]  = 0;
                  m_tone[c] = 0;
               end else begin
                  m_tone[c] = !m_tone[c];
                  m_end[c]  = cyc + nd;
               end
            end
         end else begin
            if (hit) begin m_div[c] = nd; used = 1; end
            if (key[c] && !m_keyp[c] && nd != 0) begin
               m_act[c]  = 1;
               m_tone[c] = 0;
               m_end[c]  = cyc + nd;
            end
         end
         m_keyp[c] = key[c];
      end
      if (!empty) begin
         if (used || pq[0].ch >= NCH) void'(pq.pop_front());
      end
      if (cfg_valid && empty) pq.push_back('{int'(cfg_ch), int'(cfg_div)});
      m_mix = popc;
      cyc++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   logic [NCH-1:0] exp_tone, exp_act;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int c = 0; c < NCH; c++) begin
            exp_tone[c] = m_tone[c];
            exp_act[c]  = m_act[c];
         end
         check("model_tone", tone, exp_tone);
         check("model_active", active, exp_act);
         check("model_cfg_ready", cfg_ready, pq.size() == 0);
`ifdef CHORD_MIX_OUT_EN
         check("model_mix", mix, m_mix);
`endif
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wr(input int ch, input int dv);
      int n;
      n = 0;
      while (cfg_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("wr_timeout", n, 0);
      cfg_valid = 1'b1;
      cfg_ch    = 3'(ch);
      cfg_div   = DIVW'(dv);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog at %0t: got timeout expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hi;
      rst_n = 1'b0; key = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
      key1 = '0; cfg_valid1 = 1'b0; cfg_ch1 = '0; cfg_div1 = '0;
      repeat (3) @(negedge clk);
      check("rst_tone", tone, 0);
      check("rst_active", active, 0);
      check("rst_ready", cfg_ready, 1);
      rst_n = 1'b1;

      // Out-of-range channel writes on the 6-channel instance.
      @(negedge clk);
      cfg_valid1 = 1'b1; cfg_ch1 = 3'd7; cfg_div1 = 4'd3;
      @(negedge clk);
      cfg_valid1 = 1'b0;
      check("oor_busy", cfg_ready1, 0);
      @(negedge clk);
      check("oor_free", cfg_ready1, 1);
      cfg_valid1 = 1'b1; cfg_ch1 = 3'd6; cfg_div1 = 4'd2;
      @(negedge clk);
      cfg_valid1 = 1'b0;
      @(negedge clk);
      check("oor2_free", cfg_ready1, 1);
      cfg_valid1 = 1'b1; cfg_ch1 = 3'd5; cfg_div1 = 4'd2;
      @(negedge clk);
      cfg_valid1 = 1'b0;
      @(negedge clk);
      key1 = 6'h3F;
      repeat (4) @(negedge clk);
      check("oor_active", active1, 6'h20);

      // ch3 at div=5: low 5, high 5, repeating; then key release mid-high.
      wr(3, 5);
      @(negedge clk);
      key = 8'h08;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         check("div5_tone", tone[3], (k / 5) % 2);
         check("div5_active", active[3], 1);
      end
      key = 8'h00;
      for (int k = 18; k < 27; k++) begin
         @(negedge clk);
         check("stop_tone", tone[3], (k < 20) ? 1 : 0);
         check("stop_active", active[3], k < 25);
      end

      // Back-to-back writes while ch0 runs at div=100.
      do_reset();
      wr(0, 100);
      @(negedge clk);
      key = 8'h01;
      repeat (30) @(negedge clk);
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd7;
      @(negedge clk);
      cfg_ch = 3'd1; cfg_div = 16'd4;
      check("bp_busy", cfg_ready, 0);
      n = 0;
      while (cfg_ready !== 1'b1 && n < 150) begin
         @(negedge clk);
         n++;
      end
      check("bp_release_gap", n, 70);
      @(negedge clk);
      cfg_valid = 1'b0;
      check("bp_second_busy", cfg_ready, 0);
      @(negedge clk);
      check("bp_second_free", cfg_ready, 1);
      n = 0;
      while (tone[0] !== 1'b0 && n < 300) begin @(negedge clk); n++; end
      while (tone[0] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      hi = 0;
      while (tone[0] === 1'b1 && hi < 300) begin @(negedge clk); hi++; end
      check("new_half_period", hi, 7);

      // All channels at div=1..8 (mix checked by the model when present).
      do_reset();
      key = '0;
      for (int c = 0; c < NCH; c++) wr(c, c + 1);
      @(negedge clk);
      key = 8'hFF;
      repeat (120) @(negedge clk);
      check("all_active", active, 8'hFF);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            cfg_valid = 1'b1;
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_div   = ($urandom_range(0, 5) == 0) ? '0 : DIVW'($urandom_range(1, 12));
         end else begin
            cfg_valid = 1'b0;
         end
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 15) == 0) key[c] = ~key[c];
         end
      end
      cfg_valid = 1'b0;

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tone", tone, 0);
      check("arst_active", active, 0);
      check("arst_ready", cfg_ready, 1);
`ifdef CHORD_MIX_OUT_EN
      check("arst_mix", mix, 0);
`endif
      key = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("silent_after_rst", active, 0);
      end

      // Write during reset is dropped; write at the releasing edge is taken.
      rst_n = 1'b0; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd3;
      @(negedge clk);
      cfg_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_write_dropped", cfg_ready, 1);
      rst_n = 1'b0;
      cfg_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("rel_write_taken", cfg_ready, 0);
      key = '0;
      @(negedge clk);
      key = 8'h04;
      repeat (3) @(negedge clk);
      check("rel_write_active", active, 8'h04);
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
